// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//
// Power-up loader for the instruction memory. It takes a program from a byte
// stream and holds the CPU stalled until the whole program is in memory.
//
// Stream format:
//   - The first accepted byte is a length header L, counted in 32-bit words.
//   - The next 4*L bytes are the program, sent MSB first within each word.
//
// Once all L words are written, the CPU is released. From then on the CPU's
// fetch PC owns the memory address port.
//
// Ports:
//   clk          system clock; all state updates on the rising edge
//   rst          synchronous, active-low reset
//   rx_valid     byte source has a valid byte on rx_data
//   rx_data      byte from the source
//   rx_ready     loader accepts a byte this cycle (transfer = rx_valid && rx_ready)
//   cpu_pc       CPU fetch byte address, passed through once loading is done
//   mem_addr     byte address to the instruction memory
//   mem_wdata    write data to the instruction memory
//   mem_we       single-cycle write strobe
//   cpu_run      1 = CPU may advance, 0 = CPU stalled
//   load_done    program fully written
//   load_err     length header was larger than the memory
//   words_loaded number of words written so far

module imem_boot_loader #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  input  logic [31:0]      cpu_pc,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  output logic             cpu_run,
  output logic             load_done,
  output logic             load_err,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_LEN,
    S_BYTE,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_t           state;
  state_t           state_next;
  logic [1:0]       byte_idx;
  logic [31:0]      word;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] words_inc;
  logic [31:0]      hdr_len;
  logic [31:0]      load_addr;
  logic             accept;

  // Widen the header byte once so the range check against DEPTH is
  // unsigned and width-matched for any DEPTH.
  assign hdr_len = {24'd0, rx_data};

  assign accept    = rx_valid && rx_ready;
  assign words_inc = words_loaded + CNT_W'(1);

  // The next free word slot, expressed as a byte address.
  assign load_addr = {{(30 - CNT_W){1'b0}}, words_loaded, 2'b00};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_LEN;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  //
  // The WRITE state always lasts exactly one cycle. It exits on the count
  // that words_loaded is about to take, so the last write goes straight to
  // DONE without an extra cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_LEN: begin
        if (accept) begin
          if (rx_data == 8'd0) begin
            state_next = S_DONE;
          end else if (hdr_len > DEPTH_U) begin
            state_next = S_ERR;
          end else begin
            state_next = S_BYTE;
          end
        end
      end
      S_BYTE: begin
        if (accept && byte_idx == 2'd3) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (words_inc == len) begin
          state_next = S_DONE;
        end else begin
          state_next = S_BYTE;
        end
      end
      S_DONE:  state_next = S_DONE;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_LEN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  //
  // rx_ready and the write strobe are gated by rst. This has two effects:
  //   - no byte is taken during a reset cycle;
  //   - a reset that lands on a WRITE cycle aborts that write.
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 32'd0;
    mem_addr  = load_addr;
    cpu_run   = 1'b0;
    load_done = 1'b0;
    load_err  = 1'b0;
    case (state)
      S_LEN, S_BYTE: begin
        rx_ready = rst;
      end
      S_WRITE: begin
        mem_we    = rst;
        mem_wdata = rst ? word : 32'd0;
      end
      S_DONE: begin
        cpu_run   = 1'b1;
        load_done = 1'b1;
        mem_addr  = cpu_pc;
      end
      S_ERR: begin
        load_err = 1'b1;
        mem_addr = 32'd0;
      end
      default: begin
        mem_addr = load_addr;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: length register, byte assembly and word counter
  //
  // Bytes are shifted in from the bottom, so after four bytes the first one
  // sits in [31:24]. The counter only moves while below the stored length,
  // which keeps it saturated at L.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_idx     <= 2'd0;
      word         <= 32'd0;
      len          <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        S_LEN: begin
          if (accept && hdr_len <= DEPTH_U) begin
            len <= hdr_len[CNT_W-1:0];
          end
        end
        S_BYTE: begin
          if (accept) begin
            word     <= {word[23:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          byte_idx <= 2'd0;
          if (words_loaded != len) begin
            words_loaded <= words_inc;
          end
        end
        default: begin
          byte_idx <= byte_idx;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
//
// Self-checking bench for imem_boot_loader. A cycle-level reference model
// tracks the load in terms of what has been received:
//   - whether a length header has arrived;
//   - the payload bytes taken;
//   - the words written.
// From these it predicts every output on every cycle. Directed scenarios
// cover the documented cases, and randomized loads follow them.
//
// Ports: none (top-level bench).

module tb_imem_boot_loader;

  localparam int DEPTH = 32;
  localparam int CNT_W = 6;

  logic             clk;
  logic             rst;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic [31:0]      cpu_pc;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_we;
  logic             cpu_run;
  logic             load_done;
  logic             load_err;
  logic [CNT_W-1:0] words_loaded;

  int vec_count  = 0;
  int miss_count = 0;
  int we_count   = 0;

  logic [63:0] wr_log[$];

  imem_boot_loader #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .cpu_pc      (cpu_pc),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .cpu_run     (cpu_run),
    .load_done   (load_done),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the vector and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, evaluated at each falling edge
  //
  // Outputs are compared first. Then the model absorbs the inputs that the
  // coming rising edge will commit.
  // ---------------------------------------------------------------------------
  bit          m_have_len = 0;
  bit          m_err      = 0;
  bit          m_pend     = 0;
  int          m_len      = 0;
  int          m_words    = 0;
  logic [7:0]  m_bytes[$];

  always @(negedge clk) begin
    bit          done;
    bit          exp_ready;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    if (mem_we) begin
      we_count++;
      wr_log.push_back({mem_addr, mem_wdata});
    end
    if (!rst) begin
      checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      m_have_len = 0;
      m_err      = 0;
      m_pend     = 0;
      m_len      = 0;
      m_words    = 0;
      m_bytes.delete();
    end else begin
      done      = m_have_len && (m_words == m_len);
      exp_ready = !m_err && !done && !m_pend;
      exp_addr  = done ? cpu_pc : (m_err ? 32'd0 : 32'(m_words * 4));
      exp_wd    = 32'd0;
      if (m_pend) begin
        exp_wd = {m_bytes[4*m_words], m_bytes[4*m_words+1],
                  m_bytes[4*m_words+2], m_bytes[4*m_words+3]};
      end
      checkOutput("rx_ready", 32'(rx_ready), 32'(exp_ready));
      checkOutput("mem_we", 32'(mem_we), 32'(m_pend));
      checkOutput("mem_addr", mem_addr, exp_addr);
      checkOutput("mem_wdata", mem_wdata, exp_wd);
      checkOutput("cpu_run", 32'(cpu_run), 32'(done));
      checkOutput("load_done", 32'(load_done), 32'(done));
      checkOutput("load_err", 32'(load_err), 32'(m_err));
      checkOutput("words_loaded", 32'(words_loaded), 32'(m_words));
      if (m_pend) begin
        m_words++;
        m_pend = 0;
      end else if (rx_valid && exp_ready) begin
        if (!m_have_len) begin
          if (int'(rx_data) > DEPTH) begin
            m_err = 1;
          end else begin
            m_have_len = 1;
            m_len      = int'(rx_data);
          end
        end else begin
          m_bytes.push_back(rx_data);
          if (m_bytes.size() % 4 == 0) m_pend = 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  //
  // Every task starts and ends 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    rx_valid = valid;
    rx_data  = data;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst      = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Present a byte after 'gap' idle cycles and hold it until it is taken.
  task automatic sendByte(input logic [7:0] b, input int gap);
    bit got;
    got = 0;
    for (int i = 0; i < gap; i++) applyStimulus(1'b0, 8'($urandom));
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      got = rx_ready;
      @(posedge clk);
      #1;
    end
    if (!got) checkOutput("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0]  prog[$];
    logic [7:0]  pat_bytes[4];
    logic [6:0]  pat;
    logic [31:0] w;
    int          we_before;
    int          n;
    int          len_val;
    int          lens[10];

    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    cpu_pc   = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_words", 32'(words_loaded), 32'd0);
    checkOutput("reset_cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("reset_rx_ready", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;

    // Scenario 1: three-word program, valid held high.
    $display("[TB] three-word load");
    wr_log.delete();
    prog = '{8'h20, 8'h07, 8'h00, 8'h06, 8'h20, 8'h01, 8'h00, 8'h00,
             8'h08, 8'h00, 8'h00, 8'h14};
    sendByte(8'd3, 0);
    foreach (prog[i]) sendByte(prog[i], 0);
    idle(3);
    checkOutput("s1_writes", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      checkOutput("s1_a0", wr_log[0][63:32], 32'h0);
      checkOutput("s1_d0", wr_log[0][31:0], 32'h20070006);
      checkOutput("s1_a1", wr_log[1][63:32], 32'h4);
      checkOutput("s1_d1", wr_log[1][31:0], 32'h20010000);
      checkOutput("s1_a2", wr_log[2][63:32], 32'h8);
      checkOutput("s1_d2", wr_log[2][31:0], 32'h08000014);
    end
    checkOutput("s1_words", 32'(words_loaded), 32'd3);
    cpu_pc = 32'h64;
    @(negedge clk);
    checkOutput("s1_pc_pass", mem_addr, 32'h64);
    @(posedge clk);
    #1;

    // Scenario 6: further bytes in DONE are ignored.
    we_before = we_count;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'hFF);
    checkOutput("done_no_we", 32'(we_count - we_before), 32'd0);
    checkOutput("done_words", 32'(words_loaded), 32'd3);

    // Scenario 2: zero-length program.
    $display("[TB] zero-length load");
    doReset();
    we_before = we_count;
    sendByte(8'd0, 0);
    idle(2);
    checkOutput("len0_no_we", 32'(we_count - we_before), 32'd0);
    checkOutput("len0_done", 32'(load_done), 32'd1);
    checkOutput("len0_words", 32'(words_loaded), 32'd0);

    // Scenario 3: oversize header.
    $display("[TB] oversize header");
    doReset();
    we_before = we_count;
    sendByte(8'd33, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'($urandom));
    checkOutput("err_flag", 32'(load_err), 32'd1);
    checkOutput("err_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("err_cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("err_no_we", 32'(we_count - we_before), 32'd0);

    // Scenario 4: one word with rx_valid toggling 1-0-0-1-1-0-1.
    $display("[TB] gapped single word");
    doReset();
    wr_log.delete();
    we_before = we_count;
    sendByte(8'd1, 0);
    pat = 7'b1001101;
    pat_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    n = 0;
    for (int i = 6; i >= 0; i--) begin
      if (pat[i]) begin
        applyStimulus(1'b1, pat_bytes[n]);
        n++;
      end else begin
        applyStimulus(1'b0, 8'hEE);
      end
    end
    idle(3);
    checkOutput("s4_we_cycles", 32'(we_count - we_before), 32'd1);
    if (wr_log.size() == 1) checkOutput("s4_data", wr_log[0][31:0], 32'h11223344);
    checkOutput("s4_done", 32'(load_done), 32'd1);

    // Scenario 5: reset during the second word's third byte, then reload.
    $display("[TB] reset mid-load");
    doReset();
    wr_log.delete();
    sendByte(8'd2, 0);
    for (int i = 0; i < 4; i++) sendByte(8'(8'h10 + i), 0);
    sendByte(8'hA1, 0);
    sendByte(8'hA2, 0);
    rx_valid = 1'b1;
    rx_data  = 8'hA3;
    doReset();
    idle(2);
    checkOutput("s5_writes", 32'(wr_log.size()), 32'd1);
    checkOutput("s5_words", 32'(words_loaded), 32'd0);
    checkOutput("s5_done", 32'(load_done), 32'd0);
    wr_log.delete();
    sendByte(8'd1, 0);
    sendByte(8'hAC, 0);
    sendByte(8'h03, 0);
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    idle(2);
    checkOutput("s5_rewrites", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() == 1) begin
      checkOutput("s5_addr", wr_log[0][63:32], 32'h0);
      checkOutput("s5_data", wr_log[0][31:0], 32'hAC030000);
    end
    checkOutput("s5_load_done", 32'(load_done), 32'd1);

    // Reset landing on the WRITE cycle must suppress that write.
    doReset();
    we_before = we_count;
    sendByte(8'd1, 0);
    for (int i = 0; i < 4; i++) sendByte(8'($urandom), 0);
    doReset();
    idle(2);
    checkOutput("wr_abort_no_we", 32'(we_count - we_before), 32'd0);
    checkOutput("wr_abort_words", 32'(words_loaded), 32'd0);

    // Randomized loads, including the full-depth boundary.
    $display("[TB] randomized loads");
    lens = '{32, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int k = 2; k < 10; k++) lens[k] = int'($urandom_range(1, DEPTH));
    for (int k = 0; k < 10; k++) begin
      doReset();
      wr_log.delete();
      prog.delete();
      len_val = lens[k];
      cpu_pc = $urandom;
      sendByte(8'(len_val), int'($urandom_range(0, 2)));
      for (int i = 0; i < 4 * len_val; i++) begin
        prog.push_back(8'($urandom));
        cpu_pc = $urandom;
        sendByte(prog[i], int'($urandom_range(0, 2)));
      end
      idle(3);
      checkOutput("rnd_words", 32'(words_loaded), 32'(len_val));
      checkOutput("rnd_writes", 32'(wr_log.size()), 32'(len_val));
      checkOutput("rnd_done", 32'(load_done), 32'd1);
      for (int i = 0; i < len_val && i < wr_log.size(); i++) begin
        w = {prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]};
        checkOutput("rnd_addr", wr_log[i][63:32], 32'(4 * i));
        checkOutput("rnd_data", wr_log[i][31:0], w);
      end
    end

    // Random oversize headers.
    for (int k = 0; k < 3; k++) begin
      doReset();
      we_before = we_count;
      sendByte(8'($urandom_range(DEPTH + 1, 255)), 0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'($urandom));
      checkOutput("rnd_err", 32'(load_err), 32'd1);
      checkOutput("rnd_err_no_we", 32'(we_count - we_before), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
